// File: rtl/board_cover.sv
// board_cover: per-cell cover state (covered / opened / flagged) for a game board.
// It reads the selected cell combinationally and pulses opened_cell once per successful open.
module board_cover #(
    parameter int x_size       = 16,
    parameter int y_size       = 16,
    parameter int x_coord_bits = 4,
    parameter int y_coord_bits = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flag,
    input  logic                    open,
    input  logic [x_coord_bits-1:0] x_coord,
    input  logic [y_coord_bits-1:0] y_coord,
    output logic [1:0]              cell_val,
    output logic                    opened_cell
);

    typedef enum logic [1:0] {
        COVERED = 2'b00,
        OPENED  = 2'b01,
        FLAGGED = 2'b10
    } cover_e;

    localparam int cell_count = x_size * y_size;
    localparam int idx_bits   = (cell_count > 1) ? $clog2(cell_count) : 1;

    // The declaration initialisers make the board read all-covered before the first reset.
    cover_e cells [cell_count] = '{default: COVERED};
    logic   opened_q           = 1'b0;

    logic                in_range;
    logic [idx_bits-1:0] cell_idx;
    cover_e              cur_state;

    always_comb begin
        in_range  = (int'(x_coord) < x_size) && (int'(y_coord) < y_size);
        cell_idx  = idx_bits'(int'(y_coord) * x_size + int'(x_coord));
        cur_state = in_range ? cells[cell_idx] : COVERED;
    end

    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the board is a register file rather than a RAM, so all cells clear in one cycle.
            for (int i = 0; i < cell_count; i++) begin
                cells[i] <= COVERED;
            end
            opened_q <= 1'b0;
        end else begin
            opened_q <= 1'b0;
            if (in_range) begin
                if (open) begin
                    if (cur_state == COVERED) begin
                        cells[cell_idx] <= OPENED;
                        opened_q        <= 1'b1;
                    end
                end else if (flag) begin
                    case (cur_state)
                        COVERED: cells[cell_idx] <= FLAGGED;
                        FLAGGED: cells[cell_idx] <= COVERED;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign cell_val    = cur_state;
    assign opened_cell = opened_q;

endmodule

// File: tb/tb_board_cover.sv
// Directed self-checking bench for board_cover: a default 16x16 board plus a 10-column
// instance used for out-of-range coordinate handling.
module tb_board_cover;

    logic       clk = 1'b0;
    logic       reset;
    logic       flag, open;
    logic [3:0] x_coord, y_coord;
    logic [1:0] cell_val;
    logic       opened_cell;

    logic       flag2, open2;
    logic [3:0] x2, y2;
    logic [1:0] cell_val2;
    logic       opened2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    board_cover dut (
        .clk        (clk),
        .reset      (reset),
        .flag       (flag),
        .open       (open),
        .x_coord    (x_coord),
        .y_coord    (y_coord),
        .cell_val   (cell_val),
        .opened_cell(opened_cell)
    );

    board_cover #(.x_size(10)) dut_narrow (
        .clk        (clk),
        .reset      (reset),
        .flag       (flag2),
        .open       (open2),
        .x_coord    (x2),
        .y_coord    (y2),
        .cell_val   (cell_val2),
        .opened_cell(opened2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input int x, input int y);
        x_coord = 4'(x);
        y_coord = 4'(y);
        #1;
    endtask

    task automatic pulse(input logic f, input logic o);
        flag = f;
        open = o;
        tick();
        flag = 1'b0;
        open = 1'b0;
    endtask

    initial begin
        int pulses;
        reset = 1'b0;
        flag  = 1'b0;
        open  = 1'b0;
        flag2 = 1'b0;
        open2 = 1'b0;
        x2    = 4'd0;
        y2    = 4'd0;
        sel(3, 5);
        check("pre_reset_val", cell_val, 2'b00);
        check("pre_reset_pulse", opened_cell, 1'b0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_pulse", opened_cell, 1'b0);

        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                sel(x, y);
                check($sformatf("sweep_%0d_%0d", x, y), cell_val, 2'b00);
            end
        end
        check("sweep_pulse", opened_cell, 1'b0);

        // Open (3,5): one pulse, then nothing on a repeat open.
        sel(3, 5);
        pulse(1'b0, 1'b1);
        check("open35_val", cell_val, 2'b01);
        check("open35_pulse", opened_cell, 1'b1);
        tick();
        check("open35_pulse_gone", opened_cell, 1'b0);
        pulse(1'b0, 1'b1);
        check("reopen35_val", cell_val, 2'b01);
        check("reopen35_pulse", opened_cell, 1'b0);

        // Flag / open interplay at (0,15).
        sel(0, 15);
        pulse(1'b1, 1'b0);
        check("flag015_val", cell_val, 2'b10);
        check("flag015_pulse", opened_cell, 1'b0);
        pulse(1'b0, 1'b1);
        check("open_flagged_val", cell_val, 2'b10);
        check("open_flagged_pulse", opened_cell, 1'b0);
        pulse(1'b1, 1'b0);
        check("unflag015_val", cell_val, 2'b00);
        pulse(1'b0, 1'b1);
        check("open015_val", cell_val, 2'b01);
        check("open015_pulse", opened_cell, 1'b1);

        // Simultaneous flag and open at (15,0): open wins.
        sel(15, 0);
        pulse(1'b1, 1'b1);
        check("both150_val", cell_val, 2'b01);
        check("both150_pulse", opened_cell, 1'b1);
        pulse(1'b1, 1'b0);
        check("flag_opened_val", cell_val, 2'b01);
        check("flag_opened_pulse", opened_cell, 1'b0);

        // Holding open for several cycles yields exactly one pulse.
        sel(2, 2);
        pulses = 0;
        open   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(opened_cell);
        end
        open = 1'b0;
        tick();
        pulses += int'(opened_cell);
        check("held_open_pulses", pulses, 1);
        check("held_open_val", cell_val, 2'b01);

        // Open (7,7), flag (8,8); neighbours stay covered.
        sel(7, 7);
        pulse(1'b0, 1'b1);
        sel(8, 8);
        pulse(1'b1, 1'b0);
        sel(7, 7);
        check("open77_val", cell_val, 2'b01);
        sel(8, 8);
        check("flag88_val", cell_val, 2'b10);
        sel(6, 7);
        check("nb67_val", cell_val, 2'b00);
        sel(8, 7);
        check("nb87_val", cell_val, 2'b00);
        sel(7, 8);
        check("nb78_val", cell_val, 2'b00);
        sel(9, 8);
        check("nb98_val", cell_val, 2'b00);

        // Reset with a simultaneous open on a covered cell: reset wins, no pulse.
        sel(6, 6);
        reset = 1'b1;
        open  = 1'b1;
        tick();
        reset = 1'b0;
        open  = 1'b0;
        check("reset_open_pulse", opened_cell, 1'b0);
        check("reset_open_val", cell_val, 2'b00);
        tick();
        check("reset_open_pulse_next", opened_cell, 1'b0);
        sel(7, 7);
        check("reset77_val", cell_val, 2'b00);
        sel(8, 8);
        check("reset88_val", cell_val, 2'b00);
        sel(3, 5);
        check("reset35_val", cell_val, 2'b00);
        sel(15, 0);
        check("reset150_val", cell_val, 2'b00);

        // Narrow board: column 12 is outside a 10-column board.
        x2    = 4'd12;
        y2    = 4'd0;
        #1;
        check("oob_read", cell_val2, 2'b00);
        open2 = 1'b1;
        tick();
        open2 = 1'b0;
        check("oob_open_val", cell_val2, 2'b00);
        check("oob_open_pulse", opened2, 1'b0);
        flag2 = 1'b1;
        tick();
        flag2 = 1'b0;
        check("oob_flag_val", cell_val2, 2'b00);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 10; x++) begin
                x2 = 4'(x);
                y2 = 4'(y);
                #1;
                check($sformatf("narrow_%0d_%0d", x, y), cell_val2, 2'b00);
            end
        end
        x2    = 4'd9;
        y2    = 4'd15;
        open2 = 1'b1;
        tick();
        open2 = 1'b0;
        check("narrow_edge_val", cell_val2, 2'b01);
        check("narrow_edge_pulse", opened2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_cover.md
BOARD_COVER -- requirements
Module: board_cover

Interface
REQ-001 The block SHALL have parameter x_size, default 16, meaning number of board columns.
REQ-002 The block SHALL have parameter y_size, default 16, meaning number of board rows.
REQ-003 The block SHALL have parameter x_coord_bits, default 4, meaning width of x_coord.
REQ-004 The block SHALL have parameter y_coord_bits, default 4, meaning width of y_coord.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 The block SHALL have port flag, input, 1 bit: single-cycle request to toggle the flag on the selected cell.
REQ-008 The block SHALL have port open, input, 1 bit: single-cycle request to uncover the selected cell.
REQ-009 The block SHALL have port x_coord, input, x_coord_bits: column of the selected cell.
REQ-010 The block SHALL have port y_coord, input, y_coord_bits: row of the selected cell.
REQ-011 The block SHALL have port cell_val, output, 2 bits: cover state of the selected cell.
REQ-012 The block SHALL have port opened_cell, output, 1 bit: one-cycle pulse marking a successful open.

Function
REQ-013 Storage SHALL be one 2-bit cover state per cell, x_size*y_size cells, with encoding 2'b00 covered, 2'b01 opened, 2'b10 flagged; 2'b11 SHALL never be stored.
REQ-014 cell_val SHALL be combinational: the stored state of cell (x_coord, y_coord) in the same cycle the coordinates are applied.
REQ-015 Coordinates with x_coord >= x_size or y_coord >= y_size SHALL read cell_val = 2'b00, and flag/open at such coordinates SHALL be ignored.
REQ-016 Open on a covered cell SHALL set it to opened at the clock edge; opened_cell SHALL be 1 for exactly the following cycle, coinciding with cell_val = 2'b01 for the same unchanged coordinates.
REQ-017 Open on an opened or flagged cell SHALL leave all state unchanged and SHALL NOT pulse opened_cell.
REQ-018 Flag on a covered cell SHALL set it to flagged; flag on a flagged cell SHALL set it to covered; flag on an opened cell SHALL be ignored.
REQ-019 Flag SHALL never assert opened_cell.
REQ-020 When flag and open are both high in one cycle, open SHALL take priority and flag SHALL be ignored.
REQ-021 Each cycle SHALL modify at most one cell, the one addressed in that cycle.
REQ-022 opened_cell SHALL be 0 in every cycle not covered by REQ-016, including back-to-back opens of the same cell (the second open produces no pulse).
REQ-023 Holding open high for N cycles on one covered cell SHALL yield exactly one opened_cell pulse.

Reset
REQ-024 When reset is high at a rising clk edge, every cell SHALL become covered (2'b00) and opened_cell SHALL be 0 after that edge.
REQ-025 Reset SHALL take priority over simultaneous flag/open, and no opened_cell pulse SHALL follow such a cycle.
REQ-026 Before the first reset, cell contents SHALL be all covered through initial values, so that cell_val = 2'b00 everywhere.

Verification
REQ-027 Reset, then sweep all 256 coordinates -> cell_val = 2'b00 everywhere and opened_cell = 0.
REQ-028 At (3,5), pulse open -> next cycle cell_val = 2'b01 and opened_cell = 1; the cycle after, opened_cell = 0. A second open at (3,5) -> no pulse.
REQ-029 At (0,15), pulse flag -> cell_val = 2'b10; pulse open -> unchanged, no pulse; pulse flag -> 2'b00; pulse open -> 2'b01 with pulse.
REQ-030 At (15,0), assert flag and open together -> cell_val = 2'b01, opened_cell = 1; then flag -> stays 2'b01.
REQ-031 Open (7,7), flag (8,8), then reset -> both read 2'b00, and neighbouring cells are unaffected throughout.
REQ-032 With x_size = 10 and (x_coord, y_coord) = (12,0), pulse open -> cell_val = 2'b00, no pulse, and no in-range cell changes.
